iurt_fifo_controller: RTL and testbench

Parametrised successor of the IURT Wishbone controller: bridges a Wishbone-slave CPU port to the IPDBG byte channels (down = host→target, up = target→host), with configurable RX/TX FIFOs instead of single-byte buffers. It adds occupancy reporting, sticky RX overflow, a level interrupt and a parameter readback register, while keeping the one-shot break-on-first-host-byte feature. It sits between the CPU bus and the IPDBG JTAG hub channel.

---
 rtl/iurt_pkg.sv | 41 ++++
 rtl/iurt_sync_fifo.sv | 53 +++++
 rtl/iurt_fifo_controller.sv | 131 +++++++++++++
 tb/tb_iurt_fifo_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iurt_pkg.sv
// Shared definitions for the IURT FIFO controller: register map and
// CTRL/STATUS bit layout.
package iurt_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_LEVELS = 2'd2,
    REG_PARAMS = 2'd3
  } reg_sel_e;

  localparam int CTRL_BRK_EN    = 0;
  localparam int CTRL_RX_IRQ_EN = 1;
  localparam int CTRL_TX_IRQ_EN = 2;
  localparam int ST_RX_NE       = 8;
  localparam int ST_TX_EMPTY    = 9;
  localparam int ST_TX_FULL     = 10;
  localparam int ST_RX_OVF      = 11;

  function automatic logic [31:0] status_word(
    input logic brk_en,
    input logic rx_irq_en,
    input logic tx_irq_en,
    input logic rx_ne,
    input logic tx_empty,
    input logic tx_full,
    input logic rx_ovf
  );
    logic [31:0] w;
    w                 = '0;
    w[CTRL_BRK_EN]    = brk_en;
    w[CTRL_RX_IRQ_EN] = rx_irq_en;
    w[CTRL_TX_IRQ_EN] = tx_irq_en;
    w[ST_RX_NE]       = rx_ne;
    w[ST_TX_EMPTY]    = tx_empty;
    w[ST_TX_FULL]     = tx_full;
    w[ST_RX_OVF]      = rx_ovf;
    return w;
  endfunction

endpackage

// File: rtl/iurt_sync_fifo.sv
// Single-clock FIFO with combinational head, occupancy count and
// same-cycle push+pop (a push into a full FIFO is taken when a pop frees a slot).
module iurt_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop_ok;
  logic                  push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/iurt_fifo_controller.sv
// Wishbone-slave bridge between a CPU and the IPDBG byte channels, with RX/TX
// FIFOs, occupancy/status registers, sticky RX overflow, level irq and break.
module iurt_fifo_controller
  import iurt_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:2]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        irq,
  output logic        break_pulse,
  input  logic        data_dwn_valid,
  input  logic [7:0]  data_dwn,
  output logic        data_dwn_ready,
  input  logic        data_up_ready,
  output logic        data_up_valid,
  output logic [7:0]  data_up
);

  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]           rx_head;
  logic [RX_DEPTH_LOG2:0] rx_count;
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]           tx_head;
  logic [TX_DEPTH_LOG2:0] tx_count;

  logic                 brk_en, rx_irq_en, tx_irq_en, rx_ovf;
  logic                 ack_p1, vld_p1, brk_p1, irq_p1;
  logic [31:0]          rdata_p1;
  logic [7:0]           up_byte_p1;

  reg_sel_e             sel;
  logic                 req, tx_stall, acc, wr, ctrl_wr, rx_drop, brk_hit;
  logic [31:0]          rdata_p0;
  logic [15:0]          rx_cnt16, tx_cnt16;
  logic                 unused_dat;

  assign unused_dat = ^{dat_i[31:12], dat_i[10:8]};

  iurt_sync_fifo #(.DATA_W(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(data_dwn),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  iurt_sync_fifo #(.DATA_W(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(dat_i[7:0]),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  // Stage p0: decode the bus cycle and FIFO traffic for this clock.
  always_comb begin
    sel      = reg_sel_e'(adr_i);
    req      = ce & cyc_i & stb_i & ~ack_p1;
    tx_stall = we_i & (sel == REG_DATA) & tx_full;
    acc      = req & ~tx_stall;
    wr       = acc & we_i;
    ctrl_wr  = wr & (sel == REG_CTRL);
    rx_pop   = acc & ~we_i & (sel == REG_DATA) & ~rx_empty;
    tx_push  = wr & (sel == REG_DATA);
    rx_push  = ce & data_dwn_valid & (~rx_full | rx_pop);
    rx_drop  = ce & data_dwn_valid & rx_full & ~rx_pop;
    tx_pop   = ce & data_up_ready & ~tx_empty;
    brk_hit  = data_dwn_valid & brk_en;
    rx_cnt16 = 16'(rx_count);
    tx_cnt16 = 16'(tx_count);
    rdata_p0 = '0;
    case (sel)
      REG_DATA:   rdata_p0 = {23'b0, ~rx_empty, rx_empty ? 8'h00 : rx_head};
      REG_CTRL:   rdata_p0 = status_word(brk_en, rx_irq_en, tx_irq_en, ~rx_empty,
                                         tx_empty, tx_full, rx_ovf);
      REG_LEVELS: rdata_p0 = {tx_cnt16, rx_cnt16};
      REG_PARAMS: rdata_p0 = {16'b0, 8'(TX_DEPTH_LOG2), 8'(RX_DEPTH_LOG2)};
      default:    rdata_p0 = '0;
    endcase
    if (we_i) rdata_p0 = '0;
  end

  // Stage p1: registered bus response, up-channel byte, break and irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_p1     <= 1'b0;
      rdata_p1   <= '0;
      vld_p1     <= 1'b0;
      up_byte_p1 <= '0;
      brk_p1     <= 1'b0;
      irq_p1     <= 1'b0;
      brk_en     <= 1'b1;
      rx_irq_en  <= 1'b0;
      tx_irq_en  <= 1'b0;
      rx_ovf     <= 1'b0;
    end else if (!ce) begin
      ack_p1 <= 1'b0;
      vld_p1 <= 1'b0;
      brk_p1 <= 1'b0;
    end else begin
      ack_p1 <= acc;
      if (acc) rdata_p1 <= rdata_p0;
      vld_p1 <= tx_pop;
      if (tx_pop) up_byte_p1 <= tx_head;
      brk_p1 <= brk_hit;
      irq_p1 <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);
      if (brk_hit) brk_en <= 1'b0;
      // A CTRL write landing with the first host byte keeps the written value.
      if (ctrl_wr) begin
        brk_en    <= dat_i[CTRL_BRK_EN];
        rx_irq_en <= dat_i[CTRL_RX_IRQ_EN];
        tx_irq_en <= dat_i[CTRL_TX_IRQ_EN];
      end
      if (ctrl_wr & dat_i[ST_RX_OVF]) rx_ovf <= 1'b0;
      if (rx_drop) rx_ovf <= 1'b1;
    end
  end

  assign ack_o          = ack_p1;
  assign dat_o          = rdata_p1;
  assign data_up_valid  = vld_p1;
  assign data_up        = up_byte_p1;
  assign break_pulse    = brk_p1;
  assign irq            = irq_p1;
  assign data_dwn_ready = ~rx_full;

endmodule

// File: tb/tb_iurt_fifo_controller.sv
// Bench for iurt_fifo_controller: queue-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_iurt_fifo_controller;

  localparam int RXD = 16;
  localparam int TXD = 16;

  logic        clk = 1'b0;
  logic        rst, ce, cyc, stb, we;
  logic [1:0]  adr;
  logic [31:0] wdat;
  logic [31:0] dat_o;
  logic        ack_o, irq, break_pulse;
  logic        data_dwn_valid, data_dwn_ready, data_up_ready, data_up_valid;
  logic [7:0]  data_dwn, data_up;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iurt_fifo_controller #(.RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(wdat),
    .dat_o(dat_o), .ack_o(ack_o), .irq(irq), .break_pulse(break_pulse),
    .data_dwn_valid(data_dwn_valid), .data_dwn(data_dwn), .data_dwn_ready(data_dwn_ready),
    .data_up_ready(data_up_ready), .data_up_valid(data_up_valid), .data_up(data_up)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, outputs derived from the register rules.
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  bit          m_brk_en, m_rie, m_tie, m_ovf, started;
  logic [31:0] e_dat;
  logic        e_ack, e_irq, e_brk, e_vld, e_rdy;
  logic [7:0]  e_up;

  always @(posedge clk) begin : model
    int rn, tn;
    bit acc, rpop, drop, ctrlw;
    logic [31:0] rd;
    if (rst) begin
      rx_q.delete(); tx_q.delete();
      m_brk_en = 1; m_rie = 0; m_tie = 0; m_ovf = 0;
      e_ack = 0; e_dat = 0; e_irq = 0; e_brk = 0; e_vld = 0; e_up = 0;
      started = 1;
    end else if (ce) begin
      rn = rx_q.size();
      tn = tx_q.size();
      acc  = cyc && stb && !e_ack && !(we && adr == 2'd0 && tn == TXD);
      rpop = acc && !we && adr == 2'd0 && rn > 0;
      case (adr)
        2'd0:    rd = (rn > 0) ? {23'd0, 1'b1, rx_q[0]} : 32'd0;
        2'd1:    rd = {20'd0, m_ovf, tn == TXD, tn == 0, rn > 0, 5'd0, m_tie, m_rie, m_brk_en};
        2'd2:    rd = {16'(tn), 16'(rn)};
        default: rd = 32'h0000_0404;
      endcase
      if (we) rd = 32'd0;
      e_irq = (m_rie && rn > 0) || (m_tie && tn == 0);
      e_ack = acc;
      if (acc) e_dat = rd;
      e_vld = data_up_ready && tn > 0;
      if (e_vld) e_up = tx_q.pop_front();
      if (acc && we && adr == 2'd0) tx_q.push_back(wdat[7:0]);
      if (rpop) void'(rx_q.pop_front());
      drop = data_dwn_valid && rn == RXD && !rpop;
      if (data_dwn_valid && !drop) rx_q.push_back(data_dwn);
      e_brk = data_dwn_valid && m_brk_en;
      if (e_brk) m_brk_en = 0;
      ctrlw = acc && we && adr == 2'd1;
      if (ctrlw) {m_tie, m_rie, m_brk_en} = wdat[2:0];
      if (ctrlw && wdat[11]) m_ovf = 0;
      if (drop) m_ovf = 1;
    end else begin
      e_ack = 0; e_vld = 0; e_brk = 0;
    end
    e_rdy = rx_q.size() < RXD;
  end

  logic [7:0] up_seen[$];

  always @(negedge clk) begin
    if (started) begin
      chk("ack", ack_o, e_ack);
      chk("dat_o", dat_o, e_dat);
      chk("irq", irq, e_irq);
      chk("break", break_pulse, e_brk);
      chk("up_valid", data_up_valid, e_vld);
      chk("up_data", data_up, e_up);
      chk("dwn_ready", data_dwn_ready, e_rdy);
      if (data_up_valid) up_seen.push_back(data_up);
    end
  end

  task automatic wb_wait(output logic [31:0] q);
    q = 32'hdead_beef;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ack_o) begin
        q = dat_o; cyc = 0; stb = 0; we = 0;
        return;
      end
    end
    chk("wb_timeout", 32'd1, 32'd0);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb(input logic [1:0] a, input logic w, input logic [31:0] d,
                    output logic [31:0] q);
    cyc = 1; stb = 1; adr = a; we = w; wdat = d;
    wb_wait(q);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    data_dwn_valid = 1; data_dwn = b;
    @(posedge clk); #1;
    data_dwn_valid = 0;
  endtask

  initial begin
    logic [31:0] q;
    int age;
    rst = 1; ce = 1; cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0;
    data_dwn_valid = 0; data_dwn = 0; data_up_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_ready", data_dwn_ready, 1);
    chk("rst_ack", ack_o, 0);

    wb(2'd3, 0, 0, q); chk("params", q, 32'h0000_0404);
    wb(2'd1, 0, 0, q); chk("status_rst", q, 32'h0000_0201);

    // First host byte: break one cycle later, then break_enable is gone.
    data_dwn_valid = 1; data_dwn = 8'h41;
    @(posedge clk); #1;
    data_dwn_valid = 0;
    chk("break_pulse", break_pulse, 1);
    @(posedge clk); #1;
    chk("break_once", break_pulse, 0);
    wb(2'd1, 0, 0, q); chk("status_brk", q, 32'h0000_0300);
    wb(2'd0, 0, 0, q); chk("data_41", q, 32'h0000_0141);
    wb(2'd0, 0, 0, q); chk("data_empty", q, 32'h0000_0000);

    // 17 bytes into a 16-deep RX: last one dropped, overflow sticks.
    for (int i = 0; i < 17; i++) begin
      data_dwn_valid = 1; data_dwn = 8'h10 + 8'(i);
      @(posedge clk); #1;
    end
    data_dwn_valid = 0;
    chk("rx_full_ready", data_dwn_ready, 0);
    wb(2'd2, 0, 0, q); chk("levels_16", q, 32'h0000_0010);
    wb(2'd1, 0, 0, q); chk("status_ovf", q, 32'h0000_0b00);
    wb(2'd1, 1, 32'h800, q);
    wb(2'd1, 0, 0, q); chk("ovf_clear", q, 32'h0000_0300);

    // Full RX: a DATA read and an incoming byte in the same cycle.
    cyc = 1; stb = 1; we = 0; adr = 2'd0;
    data_dwn_valid = 1; data_dwn = 8'h77;
    @(posedge clk); #1;
    data_dwn_valid = 0;
    chk("same_cycle_ack", ack_o, 1);
    chk("same_cycle_data", dat_o, 32'h0000_0110);
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    wb(2'd2, 0, 0, q); chk("levels_still_16", q, 32'h0000_0010);
    wb(2'd1, 0, 0, q); chk("no_ovf", q, 32'h0000_0300);
    for (int i = 0; i < 16; i++) begin
      wb(2'd0, 0, 0, q);
      chk("drain", q, (i < 15) ? 32'h111 + 32'(i) : 32'h177);
    end

    // TX: fill 16, 17th write stalls until the up channel drains one.
    data_up_ready = 0;
    for (int i = 0; i < 16; i++) wb(2'd0, 1, 32'hA0 + 32'(i), q);
    wb(2'd1, 0, 0, q); chk("status_tx_full", q, 32'h0000_0400);
    up_seen.delete();
    cyc = 1; stb = 1; we = 1; adr = 2'd0; wdat = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("tx_stall_ack", ack_o, 0);
    end
    data_up_ready = 1;
    wb_wait(q);
    repeat (24) @(posedge clk);
    #1;
    chk("tx_out_count", up_seen.size(), 17);
    for (int i = 0; i < 17 && i < up_seen.size(); i++)
      chk("tx_order", up_seen[i], (i < 16) ? 8'hA0 + 8'(i) : 8'hB0);
    data_up_ready = 0;

    // irq: RX level then TX-empty level.
    wb(2'd1, 1, 32'h2, q);
    repeat (2) @(posedge clk);
    #1 chk("irq_idle", irq, 0);
    send(8'h55);
    repeat (2) @(posedge clk);
    #1 chk("irq_rx", irq, 1);
    wb(2'd0, 0, 0, q); chk("data_55", q, 32'h0000_0155);
    repeat (2) @(posedge clk);
    #1 chk("irq_drained", irq, 0);
    wb(2'd1, 1, 32'h4, q);
    repeat (2) @(posedge clk);
    #1 chk("irq_tx_empty", irq, 1);
    wb(2'd1, 1, 32'h0, q);

    // Random traffic, including ce gaps and occasional mid-access reset.
    age = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      ce  = ($urandom_range(9) != 0);
      rst = ($urandom_range(499) == 0);
      data_dwn_valid = ($urandom_range(2) == 0);
      data_dwn = 8'($urandom);
      data_up_ready = (c < 2000) ? ($urandom_range(4) == 0) : ($urandom_range(3) != 0);
      if (stb) begin
        if (ack_o || rst || age > 40) begin
          cyc = 0; stb = 0; we = 0;
        end else age++;
      end else if ($urandom_range(2) == 0) begin
        cyc = 1; stb = 1; we = 1'($urandom); adr = 2'($urandom);
        wdat = $urandom; age = 0;
      end
    end
    rst = 0; ce = 1; cyc = 0; stb = 0; data_dwn_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
